uart_frame_decoder: RTL and testbench



---
 rtl/uart_frame_decoder.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses "Vnn - dddd V<LF><CR>" voltage report frames from a UART byte stream.
// Optional: define ERR_COUNT_EN to add saturating err_count/frame_count outputs.
`default_nettype none

module uart_frame_decoder #(
   parameter int NUM_CHANNELS   = 13,
   parameter int TIMEOUT_CYCLES = 65_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_tick,
   output logic [3:0]  channel,
   output logic [15:0] value,
   output logic        valid,
`ifdef ERR_COUNT_EN
   output logic [15:0] err_count,
   output logic [15:0] frame_count,
`endif
   output logic        error
);

   localparam logic [1:0] S_HUNT = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    state;
   logic [3:0]    pos;
   logic [3:0]    tens;
   logic [3:0]    units;
   logic [15:0]   digits;
   logic [TW-1:0] tcnt;

   logic       is_digit;
   logic       is_v;
   logic       byte_ok;
   logic [4:0] ch_num;
   logic       ch_ok;

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_v     = (rx_data == 8'h56);

   // Channel arithmetic deliberately wraps in 5 bits.
   assign ch_num = ({1'b0, tens} * 5'd10) + {1'b0, units};
   assign ch_ok  = (ch_num != 5'd0) && (ch_num <= 5'(NUM_CHANNELS));

   always_comb begin
      byte_ok = 1'b0;
      case (pos)
         4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9: byte_ok = is_digit;
         4'd3, 4'd5, 4'd10:                  byte_ok = (rx_data == 8'h20);
         4'd4:                               byte_ok = (rx_data == 8'h2D);
         4'd11:                              byte_ok = is_v;
         4'd12:                              byte_ok = (rx_data == 8'h0A);
         4'd13:                              byte_ok = (rx_data == 8'h0D);
         default:                            byte_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_HUNT;
         pos     <= 4'd0;
         tens    <= 4'd0;
         units   <= 4'd0;
         digits  <= 16'd0;
         tcnt    <= '0;
         channel <= 4'd0;
         value   <= 16'd0;
         valid   <= 1'b0;
         error   <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         case (state)
            S_HUNT: begin
               tcnt <= '0;
               if (rx_tick && is_v) begin
                  state <= S_RECV;
                  pos   <= 4'd1;
               end
            end
            S_RECV: begin
               if (rx_tick) begin
                  tcnt <= '0;
                  if (byte_ok) begin
                     case (pos)
                        4'd1:    tens           <= rx_data[3:0];
                        4'd2:    units          <= rx_data[3:0];
                        4'd6:    digits[15:12]  <= rx_data[3:0];
                        4'd7:    digits[11:8]   <= rx_data[3:0];
                        4'd8:    digits[7:4]    <= rx_data[3:0];
                        4'd9:    digits[3:0]    <= rx_data[3:0];
                        default: ;
                     endcase
                     if (pos == 4'd13) begin
                        state <= S_DONE;
                        pos   <= 4'd0;
                     end else begin
                        pos <= pos + 4'd1;
                     end
                  end else begin
                     error <= 1'b1;
                     if (is_v) begin
                        pos <= 4'd1;
                     end else begin
                        state <= S_HUNT;
                        pos   <= 4'd0;
                     end
                  end
               end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  error <= 1'b1;
                  state <= S_HUNT;
                  pos   <= 4'd0;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_DONE: begin
               tcnt <= '0;
               if (ch_ok) begin
                  valid   <= 1'b1;
                  channel <= 4'(ch_num - 5'd1);
                  value   <= digits;
               end else begin
                  error <= 1'b1;
               end
               // A byte arriving now is treated as position 0 of the next frame.
               if (rx_tick && is_v) begin
                  state <= S_RECV;
                  pos   <= 4'd1;
               end else begin
                  state <= S_HUNT;
                  pos   <= 4'd0;
               end
            end
            default: begin
               state <= S_HUNT;
               pos   <= 4'd0;
            end
         endcase
      end
   end

`ifdef ERR_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count   <= 16'd0;
         frame_count <= 16'd0;
      end else begin
         if (error && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
         if (valid && (frame_count != 16'hFFFF))
            frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: scoreboard bench for uart_frame_decoder with directed frames.
`default_nettype none

module tb_uart_frame_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_tick;
   logic [3:0]  channel;
   logic [15:0] value;
   logic        valid;
   logic        error;
`ifdef ERR_COUNT_EN
   logic [15:0] err_count;
   logic [15:0] frame_count;
`endif

   uart_frame_decoder #(.NUM_CHANNELS(13), .TIMEOUT_CYCLES(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_tick     (rx_tick),
      .channel     (channel),
      .value       (value),
      .valid       (valid),
`ifdef ERR_COUNT_EN
      .err_count   (err_count),
      .frame_count (frame_count),
`endif
      .error       (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      int          at;
      logic [3:0]  ch;
      logic [15:0] val;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   logic [3:0]  held_ch  = 4'd0;
   logic [15:0] held_val = 16'd0;
   int n_valid = 0;
   int n_err   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected pulse times use cyc sampled while the tick is being raised.
   task automatic push(input bit is_err, input int at);
      exp_t e;
      e.is_err = is_err;
      e.at     = at;
      e.ch     = held_ch;
      e.val    = held_val;
      q.push_back(e);
      if (is_err) n_err++; else n_valid++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         idle(gap);
      end
   endtask

   task automatic send_frame(input string body, input int gap, input bit good,
                             input logic [3:0] ch, input logic [15:0] val);
      send_str(body, gap);
      send_byte(8'h0A);
      idle(gap);
      if (good) begin
         held_ch  = ch;
         held_val = val;
      end
      push(!good, cyc + 2);
      send_byte(8'h0D);
      idle(gap);
   endtask

   always @(negedge clk) begin
      if (valid || error) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0b error=%0b at cyc %0d, required none",
                     valid, error, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (error !== e.is_err || valid !== !e.is_err || cyc != e.at ||
                channel !== e.ch || value !== e.val) begin
               errors++;
               $display("FAIL pulse: got valid=%0b error=%0b cyc=%0d ch=%0d val=%h, required err=%0b cyc=%0d ch=%0d val=%h",
                        valid, error, cyc, channel, value, e.is_err, e.at, e.ch, e.val);
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      rx_data = 8'h00;
      rx_tick = 1'b0;
      idle(3);
      chk("reset_channel", 32'(channel), 32'd0);
      chk("reset_value", 32'(value), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      rst = 1'b0;
      idle(2);

      send_frame("V01 - 1234 V", 15, 1'b1, 4'd0, 16'h1234);
      idle(4);

      send_frame("V13 - 0950 V", 0, 1'b1, 4'd12, 16'h0950);
      send_frame("V07 - 0000 V", 0, 1'b1, 4'd6, 16'h0000);
      idle(4);

      send_frame("V14 - 1111 V", 2, 1'b0, 4'd0, 16'd0);
      idle(3);
      send_frame("V00 - 1111 V", 2, 1'b0, 4'd0, 16'd0);
      idle(3);
      chk("held_channel", 32'(channel), 32'd6);
      chk("held_value", 32'(value), 32'h0000);

      send_str("V05 -", 1);
      push(1'b1, cyc + 1);
      send_byte(8'h56);
      idle(1);
      send_frame("02 - 4321 V", 1, 1'b1, 4'd1, 16'h4321);
      idle(4);

      send_str("V03 - 1", 2);
      push(1'b1, cyc + 101);
      send_byte("2");
      idle(110);
      send_frame("V09 - 9876 V", 1, 1'b1, 4'd8, 16'h9876);
      idle(5);

`ifdef ERR_COUNT_EN
      chk("frame_count_pre_reset", 32'(frame_count), 32'(n_valid));
      chk("err_count_pre_reset", 32'(err_count), 32'(n_err));
`endif

      send_str("V03 - 12", 2);
      rst = 1'b1;
      idle(2);
      chk("midreset_channel", 32'(channel), 32'd0);
      chk("midreset_value", 32'(value), 32'd0);
      held_ch  = 4'd0;
      held_val = 16'd0;
      n_valid  = 0;
      n_err    = 0;
      rst = 1'b0;
      idle(2);
      // The tail's 'V' is indistinguishable from a frame start, so the LF after it is a mismatch.
      send_str("34 V", 2);
      push(1'b1, cyc + 1);
      send_byte(8'h0A);
      idle(2);
      send_byte(8'h0D);
      idle(2);
      send_frame("V10 - 5555 V", 1, 1'b1, 4'd9, 16'h5555);
      idle(5);
      chk("final_channel", 32'(channel), 32'd9);
      chk("final_value", 32'(value), 32'h5555);

`ifdef ERR_COUNT_EN
      chk("frame_count_final", 32'(frame_count), 32'(n_valid));
      chk("err_count_final", 32'(err_count), 32'(n_err));
`endif

      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_pulse: got none, required err=%0b at cyc %0d", e.is_err, e.at);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
